// File: rtl/pipeline_mem_arbiter_if.sv
// Bundles the pipeline-side request/hit signals and the shared memory port of the arbiter.
// "slave" is the arbiter's view; "master" is the surrounding pipeline + memory.
interface pipeline_mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iHit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dHit;
  logic        halt;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_store;
  logic [31:0] mem_load;
  logic        mem_ready;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  arbState;

  // Handshake: iREN / dREN / dWEN are levels held until the matching 1-cycle
  // iHit / dHit; mem_ren / mem_wen stay high until mem_ready (or a timeout).
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, mem_load, mem_ready,
    output iload, iHit, dload, dHit, mem_ren, mem_wen, mem_addr, mem_store,
    output busy, timeout_err, arbState
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, mem_load, mem_ready,
    input  iload, iHit, dload, dHit, mem_ren, mem_wen, mem_addr, mem_store,
    input  busy, timeout_err, arbState
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Shares one memory port between instruction fetch and EX/M data accesses, with
// a data-streak limit against fetch starvation and a timeout for hung accesses.
module pipeline_mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYC  = 255,
  parameter int CNT_W        = 8
) (
  input logic                   CLK,
  input logic                   RST,
  pipeline_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IACC   = 2'd1,
    DACC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] streak;
  logic [CNT_W-1:0] toCnt;
  logic [31:0]      addrReg;
  logic [31:0]      storeReg;
  logic [31:0]      iloadReg;
  logic [31:0]      dloadReg;
  logic             renReg;
  logic             wenReg;
  logic             iHitReg;
  logic             dHitReg;
  logic             toErr;
  logic             haltPend;

  logic inAcc;
  logic iReq;
  logic dReq;
  logic grantI;
  logic grantD;
  logic accDone;
  logic accAbort;
  logic accEnd;

  always_comb begin
    inAcc    = (state == IACC) || (state == DACC);
    // A source whose hit is pulsing this cycle is still showing its old request.
    iReq     = bus.iREN & ~iHitReg;
    dReq     = (bus.dREN | bus.dWEN) & ~dHitReg;
    grantD   = (state == IDLE) & ~bus.halt & dReq & ~(iReq & (streak >= STREAK_MAX));
    grantI   = (state == IDLE) & ~bus.halt & iReq & ~grantD;
    accDone  = inAcc & bus.mem_ready;
    accAbort = inAcc & ~bus.mem_ready & (toCnt == TO_LAST);
    accEnd   = accDone | accAbort;

    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.halt)    stateNext = HALTED;
        else if (grantI) stateNext = IACC;
        else if (grantD) stateNext = DACC;
      end
      IACC, DACC: begin
        if (accEnd) stateNext = (haltPend | bus.halt) ? HALTED : IDLE;
      end
      HALTED:  stateNext = HALTED;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      streak   <= '0;
      toCnt    <= '0;
      addrReg  <= '0;
      storeReg <= '0;
      iloadReg <= '0;
      dloadReg <= '0;
      renReg   <= 1'b0;
      wenReg   <= 1'b0;
      iHitReg  <= 1'b0;
      dHitReg  <= 1'b0;
      toErr    <= 1'b0;
      haltPend <= 1'b0;
    end else begin
      iHitReg <= 1'b0;
      dHitReg <= 1'b0;

      if (grantI) begin
        renReg  <= 1'b1;
        wenReg  <= 1'b0;
        addrReg <= bus.iaddr;
      end else if (grantD) begin
        // Simultaneous dREN and dWEN is a write.
        renReg   <= ~bus.dWEN;
        wenReg   <= bus.dWEN;
        addrReg  <= bus.daddr;
        storeReg <= bus.dstore;
      end else if (accEnd) begin
        renReg <= 1'b0;
        wenReg <= 1'b0;
      end

      if (accDone) begin
        if (state == IACC) begin
          iHitReg  <= 1'b1;
          iloadReg <= bus.mem_load;
        end else begin
          dHitReg <= 1'b1;
          if (!wenReg) dloadReg <= bus.mem_load;
        end
      end

      if (grantI || grantD)             toCnt <= '0;
      else if (inAcc && !accEnd)        toCnt <= toCnt + CNT_W'(1);

      if (accAbort) toErr <= 1'b1;

      if (accEnd)                haltPend <= 1'b0;
      else if (inAcc && bus.halt) haltPend <= 1'b1;

      // Saturates so a data grant made while the fetch is masked cannot wrap it.
      if (!bus.iREN)                          streak <= '0;
      else if (grantI)                        streak <= '0;
      else if (grantD && streak < STREAK_MAX) streak <= streak + CNT_W'(1);
    end
  end

  assign bus.mem_ren     = renReg;
  assign bus.mem_wen     = wenReg;
  assign bus.mem_addr    = addrReg;
  assign bus.mem_store   = storeReg;
  assign bus.iload       = iloadReg;
  assign bus.dload       = dloadReg;
  assign bus.iHit        = iHitReg;
  assign bus.dHit        = dHitReg;
  assign bus.busy        = inAcc;
  assign bus.timeout_err = toErr;
  assign bus.arbState    = state;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter: a transaction-level reference model,
// a per-cycle compare, a hit scoreboard and literal checks per scenario.
module tb_pipeline_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TO   = 8;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pipeline_mem_arbiter_if bus();

  pipeline_mem_arbiter #(
    .MAX_D_STREAK(MAXS),
    .TIMEOUT_CYC (TO),
    .CNT_W       (8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int nCmp = 0;
  int nBad = 0;
  bit chkOn = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // ---------------- memory responder ----------------
  int memLat  = 1000;
  int waitCnt = 0;
  always @(posedge CLK) begin
    #1;
    if (bus.mem_ren || bus.mem_wen) begin
      bus.mem_ready = (waitCnt >= memLat);
      bus.mem_load  = bus.mem_ready ? memf(bus.mem_addr) : 32'h0;
      waitCnt++;
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_load  = 32'h0;
      waitCnt       = 0;
    end
  end

  // ---------------- reference model ----------------
  // mSrc: 0 no access, 1 fetch in flight, 2 data in flight.
  int          mSrc = 0;
  bit          mWrite = 0;
  logic [31:0] mAddr = 0, mStore = 0, mILoad = 0, mDLoad = 0;
  int          mAge = 0, mStreak = 0;
  bit          mHalted = 0, mHaltPend = 0, mIHit = 0, mDHit = 0, mTo = 0;
  logic [32:0] exp_q[$];

  always @(posedge CLK or posedge RST) begin
    bit nI, nD, fin, iReq, dReq, gI, gD;
    nI = 0; nD = 0; fin = 0; gI = 0; gD = 0;
    if (RST) begin
      mSrc = 0; mWrite = 0; mAddr = 0; mStore = 0; mILoad = 0; mDLoad = 0;
      mAge = 0; mStreak = 0; mHalted = 0; mHaltPend = 0; mIHit = 0; mDHit = 0; mTo = 0;
      exp_q.delete();
    end else begin
      if (mSrc != 0) begin
        if (bus.halt) mHaltPend = 1;
        if (bus.mem_ready) begin
          fin = 1;
          if (mSrc == 1) begin
            nI = 1; mILoad = bus.mem_load;
            exp_q.push_back({1'b0, mILoad});
          end else begin
            nD = 1;
            if (!mWrite) mDLoad = bus.mem_load;
            exp_q.push_back({1'b1, mDLoad});
          end
        end else if (mAge >= TO - 1) begin
          fin = 1; mTo = 1;
        end else begin
          mAge++;
        end
        if (fin) begin
          mSrc = 0;
          if (mHaltPend) mHalted = 1;
          mHaltPend = 0;
        end
      end else if (!mHalted) begin
        if (bus.halt) mHalted = 1;
        else begin
          iReq = bus.iREN && !mIHit;
          dReq = (bus.dREN || bus.dWEN) && !mDHit;
          if (dReq && !(iReq && mStreak >= MAXS)) begin
            gD = 1; mSrc = 2; mWrite = bus.dWEN; mAddr = bus.daddr; mStore = bus.dstore; mAge = 0;
          end else if (iReq) begin
            gI = 1; mSrc = 1; mWrite = 0; mAddr = bus.iaddr; mAge = 0;
          end
        end
      end
      if (!bus.iREN) mStreak = 0;
      else if (gI)   mStreak = 0;
      else if (gD)   mStreak++;
      mIHit = nI;
      mDHit = nD;
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  int          cyc = 0;
  int          dHitCnt = 0;
  bit          busyPrev = 0;
  logic [31:0] grantLog[$];

  always @(negedge CLK) begin
    logic [32:0] e;
    cyc++;
    if (chkOn) begin
      chk1 ("mem_ren", bus.mem_ren, (mSrc != 0) && !mWrite);
      chk1 ("mem_wen", bus.mem_wen, (mSrc != 0) && mWrite);
      chk32("mem_addr", bus.mem_addr, mAddr);
      if (mSrc != 0 && mWrite) chk32("mem_store", bus.mem_store, mStore);
      chk1 ("iHit", bus.iHit, mIHit);
      chk1 ("dHit", bus.dHit, mDHit);
      chk32("iload", bus.iload, mILoad);
      chk32("dload", bus.dload, mDLoad);
      chk1 ("busy", bus.busy, mSrc != 0);
      chk1 ("timeout_err", bus.timeout_err, mTo);
      if (bus.iHit || bus.dHit) begin
        nCmp++;
        if (exp_q.size() == 0) begin
          nBad++;
          $display("FAIL hit_scoreboard: got unexpected hit, expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk1 ("hit_source", bus.dHit, e[32]);
          chk32("hit_data", e[32] ? bus.dload : bus.iload, e[31:0]);
        end
      end
    end
    if (bus.dHit) dHitCnt++;
    if (bus.busy && !busyPrev) grantLog.push_back(bus.mem_addr);
    busyPrev = bus.busy;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic wait_hit(input bit data, input int budget, input string name, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (data ? bus.dHit : bus.iHit) begin
        at = cyc;
        break;
      end
    end
    nCmp++;
    if (at < 0) begin
      nBad++;
      $display("FAIL %s: got no hit, expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_strobe(input int budget, input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (bus.mem_ren || bus.mem_wen) begin
        seen = 1;
        break;
      end
    end
    chk1(name, seen, 1'b1);
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    for (int k = 0; k < budget && grantLog.size() < n; k++) step();
    chk32(name, 32'(grantLog.size()), 32'(n));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t0, t1, prev, n, saveD, strobes, busys;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.halt = 0;
    bus.mem_ready = 0; bus.mem_load = 0;
    chkOn = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    chk1 ("rst_mem_ren", bus.mem_ren, 1'b0);
    chk1 ("rst_busy", bus.busy, 1'b0);
    chk1 ("rst_timeout_err", bus.timeout_err, 1'b0);
    chk32("rst_iload", bus.iload, 32'h0);

    // Fetch and data together: data first, fetch granted in the dHit cycle.
    memLat = 1;
    step();
    bus.iaddr = 32'h100; bus.daddr = 32'h2000;
    bus.iREN = 1; bus.dREN = 1;
    wait_hit(1, 10, "both_dhit", t0);
    bus.dREN = 0;
    chk32("both_dload", bus.dload, 32'hC0DE2000);
    wait_hit(0, 10, "both_ihit", t1);
    bus.iREN = 0;
    chk32("both_iload", bus.iload, 32'hC0DE0100);
    chk32("both_order", 32'(t1 - t0), 32'd3);

    // Zero-wait memory, back-to-back fetches: one iHit every 3 cycles.
    repeat (2) step();
    memLat = 0;
    bus.iaddr = 32'h300; bus.iREN = 1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_hit(0, 10, "zw_ihit", t0);
      bus.iaddr = bus.iaddr + 32'd4;
      if (k > 0) chk32("zw_interval", 32'(t0 - prev), 32'd3);
      prev = t0;
    end
    bus.iREN = 0;
    chk32("zw_last_iload", bus.iload, 32'hC0DE0310);

    // Timeout: strobe held 8 cycles, no hit, sticky error, immediate re-grant.
    repeat (2) step();
    memLat = 1000; saveD = dHitCnt;
    bus.daddr = 32'h500; bus.dREN = 1;
    wait_strobe(10, "to_strobe");
    n = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.mem_ren) n++;
      else break;
    end
    chk32("to_strobe_len", 32'(n), 32'd8);
    chk1 ("to_err_set", bus.timeout_err, 1'b1);
    chk32("to_no_hit", 32'(dHitCnt), 32'(saveD));
    step();
    chk1 ("to_regrant", bus.mem_ren, 1'b1);
    memLat = 1;
    wait_hit(1, 10, "to_retry_dhit", t0);
    bus.dREN = 0;
    chk1 ("to_err_sticky", bus.timeout_err, 1'b1);

    // Streak limit: hung memory keeps data re-granting without hits.
    repeat (2) step();
    memLat = 1000;
    grantLog.delete();
    bus.iaddr = 32'h600; bus.daddr = 32'h700;
    bus.iREN = 1; bus.dREN = 1;
    wait_grants(5, 80, "streak_grants");
    if (grantLog.size() >= 5) begin
      for (int k = 0; k < 4; k++) chk32("streak_data_addr", grantLog[k], 32'h700);
      chk32("streak_fetch_addr", grantLog[4], 32'h600);
    end
    bus.dREN = 0; memLat = 0;
    wait_hit(0, 10, "streak_ihit", t0);
    bus.iREN = 0;

    // Write with halt during the access: write completes, then HALTED.
    repeat (2) step();
    memLat = 3;
    bus.daddr = 32'h40; bus.dstore = 32'hDEADBEEF; bus.dWEN = 1;
    wait_strobe(10, "halt_strobe");
    chk32("halt_wr_addr", bus.mem_addr, 32'h40);
    chk32("halt_wr_data", bus.mem_store, 32'hDEADBEEF);
    bus.halt = 1;
    wait_hit(1, 10, "halt_dhit", t0);
    bus.dWEN = 0;
    bus.iREN = 1;
    strobes = 0; busys = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.mem_ren || bus.mem_wen) strobes++;
      if (bus.busy) busys++;
    end
    chk32("halted_strobes", 32'(strobes), 32'd0);
    chk32("halted_busy", 32'(busys), 32'd0);
    bus.iREN = 0;

    // Reset mid-DACC: strobe drops with RST, no hit, re-grant with fresh address.
    RST = 1; step(); step(); RST = 0; bus.halt = 0;
    chk1 ("rst2_timeout_err", bus.timeout_err, 1'b0);
    memLat = 1000; saveD = dHitCnt;
    bus.daddr = 32'h800; bus.dREN = 1;
    wait_strobe(10, "rd_strobe");
    repeat (3) step();
    #2 RST = 1;
    #1;
    chk1 ("rst_mid_ren", bus.mem_ren, 1'b0);
    chk1 ("rst_mid_wen", bus.mem_wen, 1'b0);
    chk1 ("rst_mid_busy", bus.busy, 1'b0);
    step();
    bus.daddr = 32'h900;
    step();
    RST = 0;
    grantLog.delete();
    wait_grants(1, 10, "rst_regrant");
    if (grantLog.size() >= 1) chk32("rst_regrant_addr", grantLog[0], 32'h900);
    chk32("rst_no_dhit", 32'(dHitCnt), 32'(saveD));
    memLat = 1;
    wait_hit(1, 10, "rst_retry_dhit", t0);
    bus.dREN = 0;
    chk32("rst_retry_dload", bus.dload, 32'hC0DE0900);

    repeat (3) step();
    chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
